mux_arb_2to1: RTL and testbench
===============================

// Module: mux_arb_2to1
// PURPOSE
//  Merges two valid/ready source channels (A, B) onto one registered output channel.
//  It is the converging counterpart of dmux_1to2 (which fans one stream out to a/b).
//  Used wherever two CPU-side producers share one 16-bit bus, e.g. fetch vs. load/store.
//  Round-robin arbitration on contention; the output carries a source tag (out_src).
//  Tag encoding matches dmux sel, so a downstream dmux_1to2 can route responses back.
// PARAMETERS
//  DATA_W   16   width of the data payload on every channel
// PORTS
//  clk        in   1       single clock; all state changes on posedge clk
//  rst        in   1       synchronous reset, active-high
//  a_valid    in   1       source A has a word
//  a_data     in   DATA_W  source A payload
//  a_ready    out  1       A word accepted this cycle (a_valid && a_ready)
//  b_valid    in   1       source B has a word
//  b_data     in   DATA_W  source B payload
//  b_ready    out  1       B word accepted this cycle (b_valid && b_ready)
//  out_valid  out  1       output register holds a word
//  out_data   out  DATA_W  registered payload
//  out_src    out  1       0 = word came from A, 1 = from B
//  out_ready  in   1       downstream accepts (out_valid && out_ready)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_src=0, last_grant=1.
//    last_grant=1 means A wins the first contention.
//  - load_en = !out_valid || out_ready  (combinational; one-entry pipeline register).
//  - Grant is combinational from a_valid, b_valid and last_grant:
//      only A valid -> A
//      only B valid -> B
//      both valid   -> the source != last_grant
//      neither      -> none
//  - a_ready = load_en && grant==A; b_ready = load_en && grant==B; at most one is high.
//  - On a handshake: out_data<=granted data, out_src<=granted id, out_valid<=1,
//    last_grant<=granted id.
//  - If load_en && no grant: out_valid<=0 (drain). If !load_en: all output regs hold.
//  - Latency: accepted word appears on out_* exactly 1 cycle after its input handshake.
//  - Throughput: 1 word/cycle. Output drain and new load in the same cycle are legal
//    and must not create a bubble.
//  - Stall: while out_valid && !out_ready, both readys = 0 and out_data/out_src stable.
//  - last_grant updates only on an actual handshake.
//    Uncontended traffic still updates it, so the alternation is fair.
//  - Sources must hold valid/data until ready. The block never drops or duplicates
//    an accepted word.
//  - Reset mid-operation: a pending output word is discarded. The cycle after reset
//    shows out_valid=0 and readys reflect load_en=1.
//  - a_ready and b_ready are forced 0 while rst=1.
//  - No combinational path from out_ready to out_data/out_src.
//    The path from out_ready to a_ready/b_ready is permitted.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//      DATA_W default (16)
//      localparams SRC_A=1'b0, SRC_B=1'b1 (shared with dmux_1to2 sel usage)
//  - One sub-module: rr_arb_2.
//      Combinational grant from (req[1:0], last) -> gnt[1:0] one-hot.
//      Reused by the future register-file write-port arbiter.
//  - Top level holds load_en, the output register and the last_grant flop.
// TESTING  (tb_mux_arb_2to1)
//  1 Reset: assert rst 2 cycles with a_valid=b_valid=1.
//      -> out_valid=0, out_data=0, a_ready=b_ready=0.
//      -> after release, first grant goes to A.
//  2 A only, out_ready=1: a_data=16'h1234 held 1 cycle.
//      -> next cycle out_valid=1, out_data=16'h1234, out_src=0.
//  3 Contention, out_ready=1: A and B valid for 4 cycles
//    (A=16'hA000+n, B=16'hB000+n, advancing on each handshake).
//      -> out sequence A000,B000,A001,B001; out_src=0,1,0,1; no bubbles.
//  4 Backpressure: out_valid=1 with 16'h00FF, out_ready=0 for 3 cycles, A and B valid.
//      -> out_data holds 16'h00FF; a_ready=b_ready=0.
//      -> when out_ready=1 the next word loads in the same cycle.
//  5 Drain: single word from B, then both valid=0, out_ready=1.
//      -> out_valid goes 1 for exactly one cycle, then 0.
//  6 Mid-op reset: out_valid=1 (16'hBEEF) stalled, pulse rst 1 cycle.
//      -> out_valid=0, out_data=0.
//      -> next contention grants A first (last_grant restored to 1).

Source files
------------

// File: rtl/mux_arb_2to1_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU-side bus blocks: mux_arb_2to1, dmux_1to2 and
// the register-file write-port arbiter.
//   DATA_W        default payload width of every channel
//   SRC_A / SRC_B source tags; same encoding as the dmux_1to2 select, so a
//                 response can be routed back to the requester
//   gnt_t         one-hot grant vector, bit 0 = A, bit 1 = B
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int   DATA_W = 16;

    localparam logic SRC_A  = 1'b0;
    localparam logic SRC_B  = 1'b1;

    typedef logic [1:0] gnt_t;

    // Source tag for a one-hot grant. With no grant the result is SRC_A,
    // but callers only use the tag when a grant is present.
    function automatic logic gnt_to_src(input gnt_t gnt);
        return gnt[1] ? SRC_B : SRC_A;
    endfunction

endpackage : cpu_pkg

// File: rtl/mux_arb_2to1_if.sv
// -----------------------------------------------------------------------------
// mux_arb_2to1_if
// Bundles the two source channels (A, B) and the merged output channel of
// mux_arb_2to1.
//   master : the environment side (drives the sources, acts as the sink)
//   slave  : the arbiter side (consumes the sources, drives the output)
// Signals
//   a_valid/a_data/a_ready    source A handshake and payload
//   b_valid/b_data/b_ready    source B handshake and payload
//   out_valid/out_data/out_src/out_ready  merged output with source tag
// -----------------------------------------------------------------------------
interface mux_arb_2to1_if
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W
);

    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;

    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          out_ready;

    modport master (
        output a_valid, a_data,
        input  a_ready,
        output b_valid, b_data,
        input  b_ready,
        input  out_valid, out_data, out_src,
        output out_ready
    );

    modport slave (
        input  a_valid, a_data,
        output a_ready,
        input  b_valid, b_data,
        output b_ready,
        output out_valid, out_data, out_src,
        input  out_ready
    );

endinterface : mux_arb_2to1_if

// File: rtl/mux_arb_2to1_rr_arb_2.sv
// -----------------------------------------------------------------------------
// rr_arb_2
// Purely combinational two-way round-robin arbiter.
// Ports
//   i_req  [1:0]  request vector, bit 0 = A, bit 1 = B
//   i_last        id of the last source that was granted (SRC_A / SRC_B)
//   o_gnt  [1:0]  one-hot grant, all-zero when nothing is requested
// A single requester always wins. On contention the source that was not
// granted last time wins. The caller owns the "last" state and decides when
// it advances.
// -----------------------------------------------------------------------------
module rr_arb_2
    import cpu_pkg::*;
(
    input  gnt_t i_req,
    input  logic i_last,
    output gnt_t o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // Contention: the winner is whichever source is not i_last.
            2'b11:   o_gnt = (i_last == SRC_A) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : rr_arb_2

// File: rtl/mux_arb_2to1.sv
// -----------------------------------------------------------------------------
// mux_arb_2to1
// Merges two valid/ready sources (A, B) onto one registered output channel.
// On contention the sources are served round-robin. The output carries a
// source tag (out_src) so that a downstream dmux_1to2 can route responses back.
// Ports
//   clk   single clock, every state change happens on its rising edge
//   rst   synchronous reset, active-high
//   bus   mux_arb_2to1_if.slave: a_*, b_* source channels and out_* output
// The output stage is a single register. It accepts a new word whenever it
// is empty or is being drained this cycle, so a full word stream passes at
// one word per cycle. out_data and out_src come only from flops, so
// out_ready reaches only the readys and never the output payload.
// -----------------------------------------------------------------------------
module mux_arb_2to1
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W
)(
    input  logic              clk,
    input  logic              rst,
    mux_arb_2to1_if.slave     bus
);

    // ---------------------------------------------------------------- state
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_src;
    logic          r_last_grant;

    // ----------------------------------------------------------- next state
    logic          r_out_valid_next;
    logic [DW-1:0] r_out_data_next;
    logic          r_out_src_next;
    logic          r_last_grant_next;

    // ------------------------------------------------------------- wires
    logic          w_load_en;
    gnt_t          w_req;
    gnt_t          w_gnt;
    logic          w_any_gnt;
    logic          w_gnt_src;
    logic [DW-1:0] w_gnt_data;
    logic          w_handshake;

    // The register can take a word when it is empty or is being emptied now.
    assign w_load_en = !r_out_valid || bus.out_ready;

    assign w_req = {bus.b_valid, bus.a_valid};

    rr_arb_2 u_rr_arb_2 (
        .i_req  (w_req),
        .i_last (r_last_grant),
        .o_gnt  (w_gnt)
    );

    assign w_any_gnt   = |w_gnt;
    assign w_gnt_src   = gnt_to_src(w_gnt);
    assign w_handshake = w_load_en && w_any_gnt;

    // One-hot AND-OR payload select. The grant is one-hot, so at most one
    // term in each bit is active.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_data_sel
            assign w_gnt_data[gi] = (w_gnt[0] & bus.a_data[gi])
                                  | (w_gnt[1] & bus.b_data[gi]);
        end
    endgenerate

    // While in reset the readys are held low. Because of that, no source
    // treats a cycle that the reset branch discards as accepted.
    assign bus.a_ready = !rst && w_load_en && w_gnt[0];
    assign bus.b_ready = !rst && w_load_en && w_gnt[1];

    // ---------------------------------------------------- next-state logic
    always_comb begin
        r_out_valid_next  = r_out_valid;
        r_out_data_next   = r_out_data;
        r_out_src_next    = r_out_src;
        r_last_grant_next = r_last_grant;

        if (w_load_en) begin
            if (w_any_gnt) begin
                r_out_valid_next  = 1'b1;
                r_out_data_next   = w_gnt_data;
                r_out_src_next    = w_gnt_src;
                // Round-robin state advances on every accepted word, including
                // uncontended ones. This keeps the alternation fair.
                r_last_grant_next = w_gnt_src;
            end else begin
                // Drain: the word left (or there was none) and nothing replaces it.
                r_out_valid_next  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= SRC_A;
            // Pretend B was granted last, so that A wins the first contention.
            r_last_grant <= SRC_B;
        end else begin
            r_out_valid  <= r_out_valid_next;
            r_out_data   <= r_out_data_next;
            r_out_src    <= r_out_src_next;
            r_last_grant <= r_last_grant_next;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;

    // w_handshake is not needed by the datapath. It is kept as a named
    // observation point for accepted words.
    logic w_unused;
    assign w_unused = w_handshake;

endmodule : mux_arb_2to1

// File: tb/tb_mux_arb_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_2to1
// Directed bench for mux_arb_2to1. Inputs change 1 time unit after the rising
// edge. Checks run 1 unit after that, once the combinational readys have
// settled. Every expected value is written out by hand.
// -----------------------------------------------------------------------------
module tb_mux_arb_2to1;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_arb_2to1_if #(.DW(16)) bus ();

    mux_arb_2to1 #(.DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Returns 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the combinational paths settle after an input change.
    task automatic settle();
        #1;
    endtask

    logic [15:0] exp_seq [4];
    logic [15:0] na;
    logic [15:0] nb;

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.a_valid   = 1'b1;
        bus.a_data    = 16'h1234;
        bus.b_valid   = 1'b1;
        bus.b_data    = 16'h5555;
        bus.out_ready = 1'b1;

        // ---- 1: reset held 2 cycles with both sources valid
        tick();
        tick();
        settle();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_a_ready",   32'(bus.a_ready),   32'h0);
        chk("rst_b_ready",   32'(bus.b_ready),   32'h0);
        rst = 1'b0;
        settle();
        chk("rel_a_ready",   32'(bus.a_ready),   32'h1);
        chk("rel_b_ready",   32'(bus.b_ready),   32'h0);

        // ---- 2: A only, word 1234 held one cycle
        bus.b_valid = 1'b0;
        settle();
        chk("aonly_a_ready", 32'(bus.a_ready), 32'h1);
        tick();
        bus.a_valid = 1'b0;
        settle();
        chk("aonly_out_valid", 32'(bus.out_valid), 32'h1);
        chk("aonly_out_data",  32'(bus.out_data),  32'h1234);
        chk("aonly_out_src",   32'(bus.out_src),   32'h0);

        // ---- 5: drain after a single word from B (last grant becomes B)
        bus.b_valid = 1'b1;
        bus.b_data  = 16'hBBBB;
        settle();
        chk("bonly_b_ready", 32'(bus.b_ready), 32'h1);
        chk("bonly_a_ready", 32'(bus.a_ready), 32'h0);
        tick();
        bus.b_valid = 1'b0;
        settle();
        chk("drain_valid_1", 32'(bus.out_valid), 32'h1);
        chk("drain_data",    32'(bus.out_data),  32'hBBBB);
        chk("drain_src",     32'(bus.out_src),   32'h1);
        tick();
        chk("drain_valid_0", 32'(bus.out_valid), 32'h0);
        tick();
        chk("drain_valid_0b", 32'(bus.out_valid), 32'h0);

        // ---- 3: contention for 4 handshakes, sources advance on acceptance
        exp_seq[0] = 16'hA000;
        exp_seq[1] = 16'hB000;
        exp_seq[2] = 16'hA001;
        exp_seq[3] = 16'hB001;
        na = 16'hA000;
        nb = 16'hB000;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = na;
        bus.b_data  = nb;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont%0d_a_ready", i), 32'(bus.a_ready), 32'((i % 2) == 0));
            chk($sformatf("cont%0d_b_ready", i), 32'(bus.b_ready), 32'((i % 2) == 1));
            tick();
            if ((i % 2) == 0) na = na + 16'd1;
            else              nb = nb + 16'd1;
            bus.a_data = na;
            bus.b_data = nb;
            settle();
            chk($sformatf("cont%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("cont%0d_data", i),  32'(bus.out_data),  32'(exp_seq[i]));
            chk($sformatf("cont%0d_src", i),   32'(bus.out_src),   32'(i % 2));
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // ---- 4: backpressure on a held 00FF word
        bus.a_valid = 1'b1;
        bus.a_data  = 16'h00FF;
        settle();
        chk("bp_load_a_ready", 32'(bus.a_ready), 32'h1);
        tick();
        bus.out_ready = 1'b0;
        bus.a_data    = 16'hA100;
        bus.b_valid   = 1'b1;
        bus.b_data    = 16'hB100;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_valid", i),   32'(bus.out_valid), 32'h1);
            chk($sformatf("bp%0d_data", i),    32'(bus.out_data),  32'h00FF);
            chk($sformatf("bp%0d_a_ready", i), 32'(bus.a_ready),   32'h0);
            chk($sformatf("bp%0d_b_ready", i), 32'(bus.b_ready),   32'h0);
            tick();
            settle();
        end
        bus.out_ready = 1'b1;
        settle();
        // The last grant was A (00FF), so B wins and loads while 00FF drains.
        chk("bp_rel_b_ready", 32'(bus.b_ready), 32'h1);
        chk("bp_rel_a_ready", 32'(bus.a_ready), 32'h0);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        settle();
        chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_next_data",  32'(bus.out_data),  32'hB100);
        chk("bp_next_src",   32'(bus.out_src),   32'h1);

        // ---- 6: reset while BEEF is stalled
        bus.a_valid = 1'b1;
        bus.a_data  = 16'hBEEF;
        settle();
        tick();
        bus.a_valid   = 1'b0;
        bus.out_ready = 1'b0;
        settle();
        chk("mr_pre_valid", 32'(bus.out_valid), 32'h1);
        chk("mr_pre_data",  32'(bus.out_data),  32'hBEEF);
        rst         = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 16'hC0A0;
        bus.b_valid = 1'b1;
        bus.b_data  = 16'hC0B0;
        settle();
        chk("mr_rst_a_ready", 32'(bus.a_ready), 32'h0);
        chk("mr_rst_b_ready", 32'(bus.b_ready), 32'h0);
        tick();
        rst = 1'b0;
        settle();
        chk("mr_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_out_data",  32'(bus.out_data),  32'h0);
        chk("mr_out_src",   32'(bus.out_src),   32'h0);
        chk("mr_a_ready",   32'(bus.a_ready),   32'h1);
        chk("mr_b_ready",   32'(bus.b_ready),   32'h0);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        settle();
        chk("mr_first_data", 32'(bus.out_data), 32'hC0A0);
        chk("mr_first_src",  32'(bus.out_src),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: a stuck bench still ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_arb_2to1
